pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Drives enable/clear controls of the F (PC), D, E stage registers.

---
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencer for the 5-stage core.
//
// Produces the enable/clear controls for the F (PC), D and E stage registers.
// Stalls come from load-use hazards (Tuse/Tnew comparison against the E and M
// producers) and from a D-stage MDU instruction meeting a busy MDU. An M-stage
// exception or ERET produces a one-shot D/E/M/W flush with a PC redirect,
// followed by a single RECOVER cycle in which M-stage events are ignored.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active low
//   d_rs_i       D-stage rs address
//   d_rt_i       D-stage rt address
//   d_tuse_rs_i  cycles until D needs rs (3 = not used)
//   d_tuse_rt_i  cycles until D needs rt (3 = not used)
//   e_wa_i       E-stage destination register (0 = none)
//   e_tnew_i     cycles until the E result is ready
//   m_wa_i       M-stage destination register (0 = none)
//   m_tnew_i     cycles until the M result is ready
//   d_md_op_i    D holds mult/div/mfhi/mflo/mthi/mtlo
//   d_eret_i     D holds eret
//   e_md_start_i E starts an MDU op this cycle
//   e_md_div_i   qualifies e_md_start_i: 1 = div, 0 = mult
//   m_exc_i      M-stage exception or interrupt taken
//   m_eret_i     M-stage eret
//   f_en_o       PC write enable
//   d_en_o       D register enable
//   d_clr_o      D register clear
//   e_clr_o      E register bubble insert
//   demw_clr_o   flush D/E/M/W
//   epc_we_o     EPC/cause capture strobe
//   pc_sel_o     0 = seq/branch, 1 = handler, 2 = EPC
//   md_busy_o    MDU busy indicator
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d_rs_i,
  input  logic [4:0] d_rt_i,
  input  logic [1:0] d_tuse_rs_i,
  input  logic [1:0] d_tuse_rt_i,
  input  logic [4:0] e_wa_i,
  input  logic [1:0] e_tnew_i,
  input  logic [4:0] m_wa_i,
  input  logic [1:0] m_tnew_i,
  input  logic       d_md_op_i,
  input  logic       d_eret_i,
  input  logic       e_md_start_i,
  input  logic       e_md_div_i,
  input  logic       m_exc_i,
  input  logic       m_eret_i,
  output logic       f_en_o,
  output logic       d_en_o,
  output logic       d_clr_o,
  output logic       e_clr_o,
  output logic       demw_clr_o,
  output logic       epc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       md_busy_o
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  localparam logic [1:0] PC_SEQ     = 2'd0;
  localparam logic [1:0] PC_HANDLER = 2'd1;
  localparam logic [1:0] PC_EPC     = 2'd2;

  logic [0:0] st_q, st_d;
  logic [3:0] cnt_q, cnt_d;

  // -------------------------------------------------------------------------
  // Load-use hazard: one term per D-stage source operand, each checked
  // against both producers still in flight (E and M). Register 0 never
  // creates a dependency.
  // -------------------------------------------------------------------------
  logic [1:0] src_hz;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [4:0] addr;
    logic [1:0] tuse;
    assign addr = (gi == 0) ? d_rs_i : d_rt_i;
    assign tuse = (gi == 0) ? d_tuse_rs_i : d_tuse_rt_i;
    assign src_hz[gi] = (addr != 5'd0) &
                        (((addr == e_wa_i) & (tuse < e_tnew_i)) |
                         ((addr == m_wa_i) & (tuse < m_tnew_i)));
  end

  logic hz;
  logic flush;
  logic busy;
  logic stall;

  assign hz    = |src_hz;
  // M-stage events only act in RUN; in RECOVER M holds the flushed bubble.
  assign flush = (st_q == ST_RUN) & (m_exc_i | m_eret_i);
  // A start suppressed by a concurrent flush never reaches the counter, so it
  // must not report busy either.
  assign busy  = (cnt_q != 4'd0) | (e_md_start_i & ~flush);
  assign stall = hz | (d_md_op_i & busy);

  // -------------------------------------------------------------------------
  // Output decode. While reset is asserted the pipeline free-runs with no
  // clears so that reset alone never produces a flush pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    f_en_o     = 1'b1;
    d_en_o     = 1'b1;
    d_clr_o    = 1'b0;
    e_clr_o    = 1'b0;
    demw_clr_o = 1'b0;
    epc_we_o   = 1'b0;
    pc_sel_o   = PC_SEQ;
    md_busy_o  = 1'b0;
    if (rst) begin
      md_busy_o = busy;
      if (flush) begin
        // Flush wins over any stall: the redirected fetch must proceed.
        demw_clr_o = 1'b1;
        epc_we_o   = m_exc_i;
        pc_sel_o   = m_exc_i ? PC_HANDLER : PC_EPC;
      end else if (stall) begin
        f_en_o  = 1'b0;
        d_en_o  = 1'b0;
        e_clr_o = 1'b1;
      end else begin
        // eret has no delay slot: drop whatever was fetched behind it.
        d_clr_o = d_eret_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next state. RECOVER always returns to RUN after one cycle. The MDU
  // counter ignores flushes once running, and ignores a start while busy.
  // -------------------------------------------------------------------------
  always_comb begin
    st_d  = ST_RUN;
    cnt_d = cnt_q;
    if (flush) begin
      st_d = ST_RECOVER;
    end
    if (e_md_start_i & (cnt_q == 4'd0) & ~flush) begin
      cnt_d = e_md_div_i ? DIV_CYC[3:0] : MUL_CYC[3:0];
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= ST_RUN;
      cnt_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
//
// Reference model: the MDU is tracked as "the cycle number at which it goes
// idle" and the flush aftermath as a single "last cycle flushed" flag; all
// outputs are recomputed from the behavioural rules every cycle.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_md_op, d_eret, e_md_start, e_md_div, m_exc, m_eret;
  logic       f_en, d_en, d_clr, e_clr, demw_clr, epc_we, md_busy;
  logic [1:0] pc_sel;

  pipe_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_rs_i       (d_rs),
    .d_rt_i       (d_rt),
    .d_tuse_rs_i  (d_tuse_rs),
    .d_tuse_rt_i  (d_tuse_rt),
    .e_wa_i       (e_wa),
    .e_tnew_i     (e_tnew),
    .m_wa_i       (m_wa),
    .m_tnew_i     (m_tnew),
    .d_md_op_i    (d_md_op),
    .d_eret_i     (d_eret),
    .e_md_start_i (e_md_start),
    .e_md_div_i   (e_md_div),
    .m_exc_i      (m_exc),
    .m_eret_i     (m_eret),
    .f_en_o       (f_en),
    .d_en_o       (d_en),
    .d_clr_o      (d_clr),
    .e_clr_o      (e_clr),
    .demw_clr_o   (demw_clr),
    .epc_we_o     (epc_we),
    .pc_sel_o     (pc_sel),
    .md_busy_o    (md_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int cyc      = 0;
  int idle_cyc = 0;   // first cycle at which the MDU is idle
  bit in_rec   = 0;   // previous cycle was a flush

  // observed outputs of the last step
  logic o_f_en, o_d_en, o_d_clr, o_e_clr, o_demw, o_epc, o_busy;
  logic [1:0] o_pc_sel;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit src_dep(input logic [4:0] a, input logic [1:0] tuse);
    src_dep = (a != 0) && ((a == e_wa && tuse < e_tnew) || (a == m_wa && tuse < m_tnew));
  endfunction

  // One clock cycle: compare all outputs against the model, then advance.
  task automatic step(input string tag);
    int  rem;
    bit  fl, hzm, busy_m, stall_m;
    logic x_f, x_d, x_dclr, x_eclr, x_demw, x_epc, x_busy;
    logic [1:0] x_pc;
    @(negedge clk);
    rem     = (idle_cyc > cyc) ? idle_cyc - cyc : 0;
    fl      = rst && !in_rec && (m_exc || m_eret);
    hzm     = src_dep(d_rs, d_tuse_rs) || src_dep(d_rt, d_tuse_rt);
    busy_m  = (rem > 0) || (e_md_start && !fl);
    stall_m = hzm || (d_md_op && busy_m);
    if (!rst) begin
      x_f = 1; x_d = 1; x_dclr = 0; x_eclr = 0; x_demw = 0; x_epc = 0; x_pc = 0; x_busy = 0;
    end else begin
      x_demw = fl;
      x_epc  = fl && m_exc;
      x_pc   = !fl ? 2'd0 : (m_exc ? 2'd1 : 2'd2);
      x_f    = fl || !stall_m;
      x_d    = x_f;
      x_eclr = !fl && stall_m;
      x_dclr = !fl && !stall_m && d_eret;
      x_busy = busy_m;
    end
    chk({tag, ".f_en"},     {1'b0, f_en},     {1'b0, x_f});
    chk({tag, ".d_en"},     {1'b0, d_en},     {1'b0, x_d});
    chk({tag, ".d_clr"},    {1'b0, d_clr},    {1'b0, x_dclr});
    chk({tag, ".e_clr"},    {1'b0, e_clr},    {1'b0, x_eclr});
    chk({tag, ".demw_clr"}, {1'b0, demw_clr}, {1'b0, x_demw});
    chk({tag, ".epc_we"},   {1'b0, epc_we},   {1'b0, x_epc});
    chk({tag, ".pc_sel"},   pc_sel,           x_pc);
    chk({tag, ".md_busy"},  {1'b0, md_busy},  {1'b0, x_busy});
    $display("cyc=%0d %s rst=%0b f_en=%0b d_en=%0b d_clr=%0b e_clr=%0b demw=%0b epc=%0b pc_sel=%0d busy=%0b",
             cyc, tag, rst, f_en, d_en, d_clr, e_clr, demw_clr, epc_we, pc_sel, md_busy);
    o_f_en = f_en; o_d_en = d_en; o_d_clr = d_clr; o_e_clr = e_clr;
    o_demw = demw_clr; o_epc = epc_we; o_pc_sel = pc_sel; o_busy = md_busy;
    @(posedge clk);
    if (!rst) begin
      in_rec   = 0;
      idle_cyc = cyc + 1;
    end else begin
      if (rem == 0 && e_md_start && !fl)
        idle_cyc = cyc + 1 + (e_md_div ? DIV_CYC : MUL_CYC);
      in_rec = fl;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
    e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
    d_md_op = 0; d_eret = 0; e_md_start = 0; e_md_div = 0; m_exc = 0; m_eret = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 0;

    // 1: reset then idle
    step("reset0");
    step("reset1");
    rst = 1;
    step("idle");
    chk("idle_f_en", {1'b0, o_f_en}, 2'd1);
    chk("idle_busy", {1'b0, o_busy}, 2'd0);
    chk("idle_pc_sel", o_pc_sel, 2'd0);

    // 2: load-use hazard on rs
    e_wa = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 1;
    step("hz_rs");
    chk("hz_stall_f_en", {1'b0, o_f_en}, 2'd0);
    chk("hz_stall_e_clr", {1'b0, o_e_clr}, 2'd1);
    d_rs = 0;
    step("hz_r0");
    chk("hz_r0_f_en", {1'b0, o_f_en}, 2'd1);
    idle_inputs();

    // 3: mult then div latency seen by a held D-stage MD op
    e_md_start = 1; e_md_div = 0; d_md_op = 1;
    step("mul_start");
    e_md_start = 0; n = 0;
    for (int i = 0; i < 12; i++) begin
      step("mul_wait");
      if (!o_f_en) n++;
    end
    chk_int("mul_stall_cycles", n, MUL_CYC);
    e_md_start = 1; e_md_div = 1;
    step("div_start");
    e_md_start = 0; n = 0;
    for (int i = 0; i < 14; i++) begin
      step("div_wait");
      if (!o_f_en) n++;
    end
    chk_int("div_stall_cycles", n, DIV_CYC);
    idle_inputs();

    // 4: exception + eret with concurrent hazard, then RECOVER
    e_wa = 7; e_tnew = 2; d_rt = 7; d_tuse_rt = 0;
    m_exc = 1; m_eret = 1;
    step("exc_flush");
    chk("exc_demw", {1'b0, o_demw}, 2'd1);
    chk("exc_epc", {1'b0, o_epc}, 2'd1);
    chk("exc_pc_sel", o_pc_sel, 2'd1);
    chk("exc_e_clr", {1'b0, o_e_clr}, 2'd0);
    m_eret = 0;
    step("exc_recover");
    chk("rec_demw", {1'b0, o_demw}, 2'd0);
    chk("rec_f_en", {1'b0, o_f_en}, 2'd0);
    step("exc_again");
    chk("again_demw", {1'b0, o_demw}, 2'd1);
    idle_inputs();
    step("exc_recover2");

    // 5: eret flush and D-stage eret kill
    m_eret = 1;
    step("eret_flush");
    chk("eret_pc_sel", o_pc_sel, 2'd2);
    chk("eret_epc", {1'b0, o_epc}, 2'd0);
    m_eret = 0;
    step("eret_recover");
    d_eret = 1;
    step("d_eret_free");
    chk("d_eret_clr", {1'b0, o_d_clr}, 2'd1);
    e_wa = 3; e_tnew = 1; d_rs = 3; d_tuse_rs = 0;
    step("d_eret_stall");
    chk("d_eret_stall_clr", {1'b0, o_d_clr}, 2'd0);
    idle_inputs();

    // 6: flush during a div, reset mid-count
    e_md_start = 1; e_md_div = 1;
    step("div6_start");
    e_md_start = 0;
    for (int i = 0; i < 4; i++) step("div6_count");
    m_exc = 1;
    step("div6_exc");
    chk("div6_busy_flush", {1'b0, o_busy}, 2'd1);
    m_exc = 0;
    step("div6_recover");
    chk("div6_busy_rec", {1'b0, o_busy}, 2'd1);
    rst = 0;
    step("div6_rst");
    rst = 1;
    step("div6_after");
    chk("div6_busy_after", {1'b0, o_busy}, 2'd0);
    chk("div6_demw_after", {1'b0, o_demw}, 2'd0);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 49) != 0);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      e_wa       = 5'($urandom_range(0, 3));
      e_tnew     = 2'($urandom_range(0, 3));
      m_wa       = 5'($urandom_range(0, 3));
      m_tnew     = 2'($urandom_range(0, 3));
      d_md_op    = ($urandom_range(0, 2) == 0);
      d_eret     = ($urandom_range(0, 5) == 0);
      e_md_start = ($urandom_range(0, 7) == 0);
      e_md_div   = $urandom_range(0, 1) != 0;
      m_exc      = ($urandom_range(0, 9) == 0);
      m_eret     = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
